// File: rtl/store_if.sv
`default_nettype none
// ============================================================================
// Module   : store_if
// Brief    : Store-request and word-write bus shared by the MEM stage, the
//            store unit and the unified memory word array.
//            master = surrounding system, slave = store_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface store_if #(
  parameter int ADDR_WIDTH = 32
) ();
  // request side (MEM stage -> store unit)
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [31:0]           in_data;
  logic [2:0]            in_store_type;
  // write side (store unit -> memory)
  logic                  mem_wr_en;
  logic                  mem_wr_ready;
  logic [ADDR_WIDTH-3:0] mem_wr_addr;
  logic [31:0]           mem_wr_data;
  logic [3:0]            mem_byte_en;

  modport master (
    output in_valid, in_addr, in_data, in_store_type, mem_wr_ready,
    input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_byte_en
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_store_type, mem_wr_ready,
    output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_byte_en
  );
endinterface
`default_nettype wire

// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_unit
// Brief    : Converts SB/SH/SW store requests into word writes with byte
//            enables. Requests are buffered in a FIFO; stores crossing a word
//            boundary are issued as two little-endian word writes (LO, HI).
//            Optional macro STORE_MISALIGN_TRAP_EN: misaligned SH/SW are
//            rejected with an err_misaligned pulse instead of being split.
// Revision : 1.0 - initial release
// ============================================================================
module store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 512,
  parameter int DEPTH      = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  store_if.slave bus,
  output logic   idle,
  output logic   err_invalid
`ifdef STORE_MISALIGN_TRAP_EN
  ,
  output logic   err_misaligned
`endif
);
  localparam int                PTR_W      = $clog2(DEPTH);
  localparam int                WORD_W     = ADDR_WIDTH - 2;
  localparam logic [WORD_W:0]   MEM_LIMIT  = (WORD_W + 1)'(MEM_SIZE);
  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [1:0]        KIND_SB    = 2'd0;
  localparam logic [1:0]        KIND_SH    = 2'd1;

`ifdef STORE_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WR_LO = 2'd1} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WR_LO = 2'd1, WR_HI = 2'd2} state_t;
`endif

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
    logic [1:0]            kind;
  } entry_t;

  typedef struct packed {
    logic        split;
    logic [3:0]  be_lo;
    logic [3:0]  be_hi;
    logic [31:0] d_lo;
    logic [31:0] d_hi;
  } fmt_t;

  // Lane placement of one store: LO word always, HI word only when split.
  function automatic fmt_t fmt(input entry_t e);
    fmt_t       f;
    logic [1:0] off;
    off = e.addr[1:0];
    f   = '0;
    case (e.kind)
      KIND_SB: begin
        f.be_lo = 4'b0001 << off;
        f.d_lo  = {4{e.data[7:0]}};
      end
      KIND_SH: begin
        if (off == 2'd3) begin
          f.split = 1'b1;
          f.be_lo = 4'b1000;
          f.d_lo  = {e.data[7:0], 24'h0};
          f.be_hi = 4'b0001;
          f.d_hi  = {24'h0, e.data[15:8]};
        end else begin
          f.be_lo = 4'b0011 << off;
          f.d_lo  = {16'h0, e.data[15:0]} << (8 * off);
        end
      end
      default: begin
        f.split = (off != 2'd0);
        f.be_lo = 4'b1111 << off;
        f.d_lo  = e.data << (8 * off);
        f.be_hi = 4'b1111 >> (4 - off);
        f.d_hi  = e.data >> (8 * (4 - off));
      end
    endcase
    return f;
  endfunction

  function automatic logic in_range(input logic [WORD_W-1:0] w);
    return {1'b0, w} < MEM_LIMIT;
  endfunction

  entry_t             fifo_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  state_t             state_q, state_d;
  entry_t             work_q, work_d;
  logic               armed_q, armed_d;
  logic               mem_wr_en_q, mem_wr_en_d;
  logic [WORD_W-1:0]  mem_wr_addr_q, mem_wr_addr_d;
  logic [31:0]        mem_wr_data_q, mem_wr_data_d;
  logic [3:0]         mem_byte_en_q, mem_byte_en_d;
  logic               err_invalid_q, err_invalid_d;
`ifdef STORE_MISALIGN_TRAP_EN
  logic               err_misaligned_q, err_misaligned_d;
  logic               misaligned;
`endif

  logic               full, empty, accept, kind_ok, push, pop, cur_is_hi;
  entry_t             head, in_entry;
  fmt_t               cur_fmt, head_fmt;
  logic [WORD_W-1:0]  cur_lo_word, cur_word;
  logic               load;
  logic [WORD_W-1:0]  load_addr;
  logic [31:0]        load_data;
  logic [3:0]         load_be;

  assign full        = (count_q == FULL_COUNT);
  assign empty       = (count_q == '0);
  assign head        = fifo_q[rd_ptr_q];
  assign cur_fmt     = fmt(work_q);
  assign head_fmt    = fmt(head);
  assign cur_lo_word = work_q.addr[ADDR_WIDTH-1:2];
`ifdef STORE_MISALIGN_TRAP_EN
  assign cur_is_hi   = 1'b0;
`else
  assign cur_is_hi   = (state_q == WR_HI);
`endif
  assign cur_word    = cur_is_hi ? cur_lo_word + WORD_W'(1) : cur_lo_word;

  assign bus.in_ready    = !full;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_wr_addr = mem_wr_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.mem_byte_en = mem_byte_en_q;
  assign idle            = empty && (state_q == IDLE);
  assign err_invalid     = err_invalid_q;
`ifdef STORE_MISALIGN_TRAP_EN
  assign err_misaligned  = err_misaligned_q;
`endif

  // Request acceptance: classify the incoming store and decide whether it is queued.
  always_comb begin
    accept   = bus.in_valid && !full;
    kind_ok  = (bus.in_store_type[2] == 1'b0) && (bus.in_store_type[1:0] != 2'b11);
    in_entry = '{addr: bus.in_addr, data: bus.in_data, kind: bus.in_store_type[1:0]};
    err_invalid_d = accept && !kind_ok;
`ifdef STORE_MISALIGN_TRAP_EN
    misaligned = (bus.in_store_type[1:0] == KIND_SH) ? (bus.in_addr[1:0] == 2'd3)
                                                     : (bus.in_addr[1:0] != 2'd0);
    misaligned = misaligned && (bus.in_store_type[1:0] != KIND_SB);
    err_misaligned_d = accept && kind_ok && misaligned;
    push = accept && kind_ok && !misaligned;
`else
    push = accept && kind_ok;
`endif
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Sequencer: the mem_* registers are loaded with the next phase on the
  // handshake edge itself so back-to-back writes issue every cycle. armed_q
  // marks that the registered outputs already hold the current phase.
  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    armed_d       = armed_q;
    mem_wr_en_d   = mem_wr_en_q;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_byte_en_d = mem_byte_en_q;
    pop           = 1'b0;
    load          = 1'b0;
    load_addr     = '0;
    load_data     = '0;
    load_be       = '0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          work_d      = head;
          state_d     = WR_LO;
          armed_d     = 1'b0;
          mem_wr_en_d = 1'b0;
        end
      end
      default: begin
        if (!armed_q && in_range(cur_word)) begin
          armed_d       = 1'b1;
          mem_wr_en_d   = 1'b1;
          mem_wr_addr_d = cur_word;
          mem_wr_data_d = cur_is_hi ? cur_fmt.d_hi  : cur_fmt.d_lo;
          mem_byte_en_d = cur_is_hi ? cur_fmt.be_hi : cur_fmt.be_lo;
        end else if (!armed_q || bus.mem_wr_ready) begin
          // Phase finished: written, or dropped because it is out of range.
`ifndef STORE_MISALIGN_TRAP_EN
          if (!cur_is_hi && cur_fmt.split) begin
            state_d   = WR_HI;
            load      = 1'b1;
            load_addr = cur_lo_word + WORD_W'(1);
            load_data = cur_fmt.d_hi;
            load_be   = cur_fmt.be_hi;
          end else
`endif
          if (!empty) begin
            pop       = 1'b1;
            work_d    = head;
            state_d   = WR_LO;
            load      = 1'b1;
            load_addr = head.addr[ADDR_WIDTH-1:2];
            load_data = head_fmt.d_lo;
            load_be   = head_fmt.be_lo;
          end else begin
            state_d     = IDLE;
            armed_d     = 1'b0;
            mem_wr_en_d = 1'b0;
          end
          if (load) begin
            armed_d       = in_range(load_addr);
            mem_wr_en_d   = in_range(load_addr);
            mem_wr_addr_d = load_addr;
            mem_wr_data_d = load_data;
            mem_byte_en_d = load_be;
          end
        end
      end
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= in_entry;
  end

  // State, pointer and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      state_q          <= IDLE;
      work_q           <= '0;
      armed_q          <= 1'b0;
      mem_wr_en_q      <= 1'b0;
      mem_wr_addr_q    <= '0;
      mem_wr_data_q    <= '0;
      mem_byte_en_q    <= '0;
      err_invalid_q    <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      err_misaligned_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      state_q          <= state_d;
      work_q           <= work_d;
      armed_q          <= armed_d;
      mem_wr_en_q      <= mem_wr_en_d;
      mem_wr_addr_q    <= mem_wr_addr_d;
      mem_wr_data_q    <= mem_wr_data_d;
      mem_byte_en_q    <= mem_byte_en_d;
      err_invalid_q    <= err_invalid_d;
`ifdef STORE_MISALIGN_TRAP_EN
      err_misaligned_q <= err_misaligned_d;
`endif
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_unit
// Brief    : Self-checking bench for store_unit. A byte-level reference model
//            queues the expected word writes at acceptance; a monitor pops and
//            compares them on every memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_unit;
  localparam int AW       = 32;
  localparam int MEM_SIZE = 512;
  localparam int DEPTH    = 4;

  typedef struct {
    logic [29:0] word;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic ready_ctl = 1'b1;
  logic rand_bit  = 1'b1;
  logic rand_mode = 1'b0;
  logic idle, err_invalid;
`ifdef STORE_MISALIGN_TRAP_EN
  logic err_misaligned;
`endif

  wr_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_writes = 0;

  logic        prev_stall = 1'b0;
  logic [29:0] prev_addr  = '0;
  logic [31:0] prev_data  = '0;
  logic [3:0]  prev_be    = '0;

  store_if #(.ADDR_WIDTH(AW)) bus ();
  assign bus.mem_wr_ready = rand_mode ? rand_bit : ready_ctl;

  store_unit #(.ADDR_WIDTH(AW), .MEM_SIZE(MEM_SIZE), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .idle           (idle),
`ifdef STORE_MISALIGN_TRAP_EN
    .err_misaligned (err_misaligned),
`endif
    .err_invalid    (err_invalid)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 rand_bit = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: place each byte at its own address, group by word.
  task automatic expect_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    int          n;
    logic [31:0] ba;
    logic [29:0] w0;
    logic [29:0] w;
    logic [3:0]  be [2];
    logic [31:0] dt [2];
    int          k;
    if (t > 3'd2) return;
    n = (t == 3'd0) ? 1 : (t == 3'd1) ? 2 : 4;
`ifdef STORE_MISALIGN_TRAP_EN
    if (t != 3'd0 && ((a[1:0] + 2'(n - 1)) < a[1:0] || (t == 3'd2 && a[1:0] != 2'd0))) return;
`endif
    w0 = a[31:2];
    be[0] = '0; be[1] = '0; dt[0] = '0; dt[1] = '0;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      k  = (ba[31:2] == w0) ? 0 : 1;
      be[k][ba[1:0]] = 1'b1;
      dt[k][8*ba[1:0] +: 8] = d[8*i +: 8];
    end
    if (t == 3'd0) dt[0] = {4{d[7:0]}};
    for (int j = 0; j < 2; j++) begin
      w = w0 + 30'(j);
      if (be[j] != 4'b0 && w < 30'(MEM_SIZE)) sb.push_back('{word: w, be: be[j], data: dt[j]});
    end
  endtask

  // Monitor: compare each handshake against the scoreboard; held outputs must not move.
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_en",   bus.mem_wr_en,   1);
      check("stall_addr", bus.mem_wr_addr, prev_addr);
      check("stall_data", bus.mem_wr_data, prev_data);
      check("stall_be",   bus.mem_byte_en, prev_be);
    end
    if (rst_n && bus.mem_wr_en && bus.mem_wr_ready) begin
      n_writes <= n_writes + 1;
      if (sb.size() == 0) check("unexpected_write", {32'h0, bus.mem_wr_data}, 64'hBAD);
      else begin
        check("wr_addr", bus.mem_wr_addr, sb[0].word);
        check("wr_be",   bus.mem_byte_en, sb[0].be);
        check("wr_data", bus.mem_wr_data, sb[0].data);
        sb.pop_front();
      end
    end
    prev_stall <= rst_n && bus.mem_wr_en && !bus.mem_wr_ready;
    prev_addr  <= bus.mem_wr_addr;
    prev_data  <= bus.mem_wr_data;
    prev_be    <= bus.mem_byte_en;
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    bit done = 1'b0;
    bus.in_valid = 1'b1; bus.in_addr = a; bus.in_data = d; bus.in_store_type = t;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        expect_store(a, d, t);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic drain(input string tag);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(idle && sb.size() == 0) && i < 600);
    check(tag, {31'h0, idle && (sb.size() == 0)}, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int w_before;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0; bus.in_store_type = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_wr_en", bus.mem_wr_en, 0);
    check("rst_be", bus.mem_byte_en, 0);
    check("rst_addr", bus.mem_wr_addr, 0);
    check("rst_data", bus.mem_wr_data, 0);
    check("rst_err_invalid", err_invalid, 0);
    @(posedge clk); #1;

    // Aligned SW: two-cycle latency, idle the cycle after the write
    send(32'h10, 32'hDEADBEEF, 3'b010);
    @(negedge clk); check("lat_cycle1", bus.mem_wr_en, 0);
    @(negedge clk); check("lat_cycle2", bus.mem_wr_en, 0);
    @(negedge clk); check("lat_cycle3", bus.mem_wr_en, 1);
    @(negedge clk); check("lat_idle", idle, 1);
    @(posedge clk); #1;

    // SB, split SH, split SW back to back
    send(32'h0B, 32'h000000A5, 3'b000);
    send(32'h07, 32'h00001234, 3'b001);
`ifdef STORE_MISALIGN_TRAP_EN
    @(negedge clk); check("err_misaligned", err_misaligned, 1);
    @(posedge clk); #1;
`endif
    send(32'h0E, 32'h11223344, 3'b010);
    drain("drain_basic");

    // Back-pressure: 5 stores fill FIFO plus working register
    ready_ctl = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h20 + 32'(i), 32'h50 + 32'(i), 3'b000);
    @(negedge clk);
    check("full_in_ready", bus.in_ready, 0);
    check("full_wr_en", bus.mem_wr_en, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 ready_ctl = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_wr_en && bus.mem_wr_ready) cnt++;
    end
    check("burst_writes", cnt, 5);
    drain("drain_burst");

    // Out-of-range words and wrap of the HI word index
    send(32'h800, 32'h12345678, 3'b010);
    send(32'h7FE, 32'hCAFEF00D, 3'b010);
    send(32'h7FF, 32'h0000BEEF, 3'b001);
    send(32'hFFFF_FFFE, 32'h01020304, 3'b010);
    drain("drain_range");

    // Unsupported store types
    send(32'h40, 32'h99, 3'b011);
    @(negedge clk); check("err_invalid_pulse", err_invalid, 1);
    @(negedge clk); check("err_invalid_clear", err_invalid, 0);
    check("err_invalid_idle", idle, 1);
    @(posedge clk); #1;
    send(32'h44, 32'h98, 3'b111);
    @(negedge clk); check("err_invalid_111", err_invalid, 1);
    @(posedge clk); #1;

`ifndef STORE_MISALIGN_TRAP_EN
    // Reset while the HI half of a split store is pending
    ready_ctl = 1'b0;
    send(32'h0E, 32'h11223344, 3'b010);
    send(32'h30, 32'h77, 3'b000);
    cnt = 0;
    while (!bus.mem_wr_en && cnt < 20) begin @(negedge clk); cnt++; end
    check("lo_armed_addr", bus.mem_wr_addr, 3);
    @(posedge clk); #1 ready_ctl = 1'b1;
    @(posedge clk); #1 ready_ctl = 1'b0;
    @(negedge clk);
    check("hi_armed_en", bus.mem_wr_en, 1);
    check("hi_armed_addr", bus.mem_wr_addr, 4);
    check("hi_armed_be", bus.mem_byte_en, 4'b0011);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_hi_wr_en", bus.mem_wr_en, 0);
    check("rst_hi_idle", idle, 1);
    check("rst_hi_in_ready", bus.in_ready, 1);
    @(posedge clk); #1 ready_ctl = 1'b1;
    w_before = n_writes;
    repeat (10) @(negedge clk);
    check("rst_hi_no_writes", n_writes - w_before, 0);
    check("rst_hi_still_idle", idle, 1);
    @(posedge clk); #1;
`endif

    // Random traffic with random back-pressure
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] t;
      t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      send(32'($urandom_range(0, 32'h87F)), $urandom, t);
    end
    drain("drain_random");
    rand_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side counterpart to the instruction/data memory read port; converts RISC-V SB/SH/SW store requests into word-wide memory writes with byte enables.
- Buffers stores in a small FIFO.
- Splits stores that cross a word boundary into two sequential word writes (little-endian).
- Sits between the MEM stage and the 32-bit word array of the unified memory.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- MEM_SIZE, 512, number of 32-bit words in the target memory.
- DEPTH, 4, store FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  store request valid.
- in_ready  output  1  request accepted this cycle when in_valid && in_ready.
- in_addr  input  ADDR_WIDTH  byte address.
- in_data  input  32  store data, right-aligned.
- in_store_type  input  3  funct3: 000 SB, 001 SH, 010 SW.
- mem_wr_en  output  1  word write strobe.
- mem_wr_ready  input  1  memory accepts the write this cycle.
- mem_wr_addr  output  ADDR_WIDTH-2  word index.
- mem_wr_data  output  32  lane-aligned write data.
- mem_byte_en  output  4  per-byte write enable; bit k = byte lane k.
- idle  output  1  FIFO empty and sequencer in IDLE; used for fence/drain.
- err_invalid  output  1  one-cycle pulse when an unsupported store_type is accepted.

Behaviour:
- Reset (rst_n low at a clk edge):
  - FIFO is emptied and the sequencer goes to IDLE.
  - mem_wr_en=0, mem_byte_en=0, mem_wr_addr=0, mem_wr_data=0, err_invalid=0.
  - Next cycle: in_ready=1, idle=1.
  - Reset mid-operation discards all queued and in-flight stores; a half-written split store is not completed.
- Input handshake:
  - in_ready = !full; there is no same-cycle pass-through when full.
  - Accepted SB/SH/SW entries are pushed into the FIFO.
  - Any other in_store_type is accepted but not queued; err_invalid pulses the following cycle.
- Per entry, let off = addr[1:0] and w = addr[ADDR_WIDTH-1:2].
  - SB: data={4{d[7:0]}}, be=0001<<off. Never split.
  - SH, off 0..2: data=d[15:0]<<(8*off), be=0011<<off.
  - SH, off 3: split. LO: be=1000, byte3=d[7:0]. HI: word w+1, be=0001, byte0=d[15:8].
  - SW, off 0: be=1111, data=d.
  - SW, off k in 1..3: split. LO: be=(1111<<k)[3:0], data=d<<(8k). HI: word w+1, be=1111>>(4-k), data=d>>(8*(4-k)).
  - w+1 wraps modulo 2^(ADDR_WIDTH-2).
- Sequencer states IDLE, WR_LO, WR_HI:
  - IDLE: if the FIFO is non-empty, pop the head into the working register and go to WR_LO.
  - WR_LO: drive the LO word and hold it stable until mem_wr_ready.
    - On the handshake: if the store is split, go to WR_HI.
    - Otherwise, if the FIFO is non-empty, pop and stay in WR_LO (one store per cycle sustained).
    - Otherwise go to IDLE.
  - WR_HI: drive the HI word. On the handshake, pop-and-go-WR_LO or go to IDLE, as in WR_LO.
- Out-of-range word index (>= MEM_SIZE): that phase holds mem_wr_en=0 for one cycle and advances regardless of mem_wr_ready, so the write is silently dropped.
- All mem_* outputs are registered. Latency from acceptance at edge N to mem_wr_en high is 2 cycles (N+2) with the FIFO empty.
- Ordering: writes reach memory strictly in acceptance order. LO is always written before HI.
- Push and pop in the same cycle are allowed at any occupancy below full; occupancy is unchanged.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- When defined:
  - Adds output err_misaligned (1 bit).
  - Any accepted SH with off 3, or SW with off != 0, is not queued.
  - err_misaligned pulses one cycle after acceptance; no memory write occurs.
  - The WR_HI state is omitted.
- When undefined: no err_misaligned port; splitting works as above.

Test Plan:
- Reset, then SW addr 0x10, data 0xDEADBEEF, mem_wr_ready=1 -> two cycles later mem_wr_en=1, addr=4, be=1111, data=0xDEADBEEF; idle returns to 1 the cycle after.
- SB addr 0x0B, data 0x000000A5 -> addr=2, be=1000, data=0xA5A5A5A5.
- SH addr 0x07, data 0x1234 -> cycle 1: addr=1, be=1000, byte3=0x34. Cycle 2: addr=2, be=0001, byte0=0x12. (Trap build: err_misaligned pulse, no write.)
- SW addr 0x0E, data 0x11223344 -> addr=3, be=1100, data[31:16]=0x3344; then addr=4, be=0011, data[15:0]=0x1122.
- Hold mem_wr_ready=0 and push 5 SB stores -> in_ready=0 after the 4th is queued plus one held in the working register. Release mem_wr_ready -> 5 writes in order, one per cycle, with outputs stable while stalled.
- SW addr 0x800 (word 512 >= MEM_SIZE) -> no mem_wr_en, idle returns to 1.
- Store type 011 -> err_invalid pulse, no write.
- rst_n low during WR_HI -> no HI write, FIFO empty.
